// File: rtl/pipelined_ext_adder.sv
// Pipelined adder of a wide operand A and a zero/sign-extended narrow operand B.
// Each stage adds one SEG_WIDTH slice with a registered carry. The whole pipe stalls on output backpressure.
module pipelined_ext_adder #(
   parameter int A_WIDTH   = 48,
   parameter int B_WIDTH   = 14,
   parameter int SEG_WIDTH = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [A_WIDTH-1:0] in_a,
   input  logic [B_WIDTH-1:0] in_b,
   input  logic               in_signed,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [A_WIDTH:0]   out_sum
);

   localparam int SEG     = (SEG_WIDTH < 1) ? 1 : SEG_WIDTH;
   localparam int NUM_SEG = (A_WIDTH + SEG - 1) / SEG;
   localparam int PW      = NUM_SEG * SEG;
   localparam int SKW     = (NUM_SEG > 1) ? NUM_SEG - 1 : 1;

   if (B_WIDTH > A_WIDTH || B_WIDTH < 1 || SEG_WIDTH < 1) begin : g_cfg_err
      $error("pipelined_ext_adder: illegal parameters (need 1 <= B_WIDTH <= A_WIDTH, SEG_WIDTH >= 1)");
   end

   logic               en;
   logic [A_WIDTH-1:0] b_ext;

   // Operands are zero-padded to PW bits. Skew registers shift right each stage,
   // so every stage reads its slice from bit 0.
   logic [PW-1:0] a_q   [SKW];
   logic [PW-1:0] b_q   [SKW];
   logic [PW-1:0] a_n   [SKW];
   logic [PW-1:0] b_n   [SKW];
   logic [PW-1:0] s_q   [NUM_SEG];
   logic [PW-1:0] s_n   [NUM_SEG];
   logic          c_q   [NUM_SEG];
   logic          c_n   [NUM_SEG];
   logic          v_q   [NUM_SEG];
   logic          v_n   [NUM_SEG];
   logic [PW-1:0] a_src [NUM_SEG];
   logic [PW-1:0] b_src [NUM_SEG];
   logic [PW-1:0] s_src [NUM_SEG];
   logic          c_src [NUM_SEG];
   logic          v_src [NUM_SEG];
   logic [SEG:0]  seg_res;
   logic [PW:0]   sum_full;

   assign en       = !out_valid || out_ready;
   assign in_ready = en;

   always_comb begin
      b_ext = A_WIDTH'(in_b);
      if (in_signed) b_ext = A_WIDTH'($signed(in_b));
   end

   always_comb begin
      a_src[0] = PW'(in_a);
      b_src[0] = PW'(b_ext);
      s_src[0] = '0;
      c_src[0] = 1'b0;
      v_src[0] = in_valid;
      for (int k = 1; k < NUM_SEG; k++) begin
         a_src[k] = a_q[k-1];
         b_src[k] = b_q[k-1];
         s_src[k] = s_q[k-1];
         c_src[k] = c_q[k-1];
         v_src[k] = v_q[k-1];
      end
   end

   // Finished slices enter the accumulated sum from the top and move down one slice per stage.
   always_comb begin
      seg_res = '0;
      for (int k = 0; k < SKW; k++) begin
         a_n[k] = '0;
         b_n[k] = '0;
      end
      for (int k = 0; k < NUM_SEG; k++) begin
         seg_res = {1'b0, a_src[k][SEG-1:0]} + {1'b0, b_src[k][SEG-1:0]}
                 + {{SEG{1'b0}}, c_src[k]};
         s_n[k]  = (s_src[k] >> SEG) | (PW'(seg_res[SEG-1:0]) << (PW - SEG));
         c_n[k]  = seg_res[SEG];
         v_n[k]  = v_src[k];
         if (k < NUM_SEG - 1) begin
            a_n[k] = a_src[k] >> SEG;
            b_n[k] = b_src[k] >> SEG;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < NUM_SEG; k++) begin
            s_q[k] <= '0;
            c_q[k] <= 1'b0;
            v_q[k] <= 1'b0;
         end
         for (int k = 0; k < SKW; k++) begin
            a_q[k] <= '0;
            b_q[k] <= '0;
         end
      end else if (en) begin
         for (int k = 0; k < NUM_SEG; k++) begin
            s_q[k] <= s_n[k];
            c_q[k] <= c_n[k];
            v_q[k] <= v_n[k];
         end
         for (int k = 0; k < SKW; k++) begin
            a_q[k] <= a_n[k];
            b_q[k] <= b_n[k];
         end
      end
   end

   // When the slices are padded past A_WIDTH, the carry-out is already at bit A_WIDTH of the padded sum.
   assign sum_full  = {c_q[NUM_SEG-1], s_q[NUM_SEG-1]};
   assign out_sum   = sum_full[A_WIDTH:0];
   assign out_valid = v_q[NUM_SEG-1];

endmodule

// File: tb/tb_pipelined_ext_adder.sv
// Directed and random checks of pipelined_ext_adder: the default configuration plus three parameter sweeps.
module tb_pipelined_ext_adder;

   logic        clk;
   logic        reset;
   logic        in_valid, in_ready, in_signed, out_valid, out_ready;
   logic [47:0] in_a;
   logic [13:0] in_b;
   logic [48:0] out_sum;

   logic        w_valid, w_s, w_oready;
   logic [63:0] w_a;
   logic [13:0] w_b;
   logic        r8, v8, r50a, v50a, r50b, v50b;
   logic [32:0] sum8;
   logic [50:0] sum50a, sum50b;

   int n_cmp = 0;
   int n_err = 0;
   int n_out = 0, n8 = 0, n50a = 0, n50b = 0;
   logic [63:0] q_main[$], q8[$], q50a[$], q50b[$];

   pipelined_ext_adder u_dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_signed(in_signed),
      .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum));

   pipelined_ext_adder #(.A_WIDTH(32), .B_WIDTH(8), .SEG_WIDTH(8)) u_s8 (
      .clk(clk), .reset(reset), .in_valid(w_valid), .in_ready(r8),
      .in_a(w_a[31:0]), .in_b(w_b[7:0]), .in_signed(w_s),
      .out_valid(v8), .out_ready(w_oready), .out_sum(sum8));

   pipelined_ext_adder #(.A_WIDTH(50), .B_WIDTH(14), .SEG_WIDTH(16)) u_w50 (
      .clk(clk), .reset(reset), .in_valid(w_valid), .in_ready(r50a),
      .in_a(w_a[49:0]), .in_b(w_b), .in_signed(w_s),
      .out_valid(v50a), .out_ready(w_oready), .out_sum(sum50a));

   pipelined_ext_adder #(.A_WIDTH(50), .B_WIDTH(14), .SEG_WIDTH(64)) u_w64 (
      .clk(clk), .reset(reset), .in_valid(w_valid), .in_ready(r50b),
      .in_a(w_a[49:0]), .in_b(w_b), .in_signed(w_s),
      .out_valid(v50b), .out_ready(w_oready), .out_sum(sum50b));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] ref_add(input int aw, input int bw,
                                           input logic [63:0] a, input logic [63:0] b,
                                           input bit s);
      logic [63:0] mask, ext;
      mask = (64'd1 << aw) - 64'd1;
      ext  = b;
      if (s && b[bw-1]) ext = b | ~((64'd1 << bw) - 64'd1);
      return (a & mask) + (ext & mask);
   endfunction

   // Scoreboard: record every accepted operand set at its capture edge.
   always @(posedge clk) begin
      if (reset) begin
         q_main.delete(); q8.delete(); q50a.delete(); q50b.delete();
      end else begin
         if (in_valid && in_ready)
            q_main.push_back(ref_add(48, 14, 64'(in_a), 64'(in_b), in_signed));
         if (w_valid && r8)
            q8.push_back(ref_add(32, 8, 64'(w_a[31:0]), 64'(w_b[7:0]), w_s));
         if (w_valid && r50a)
            q50a.push_back(ref_add(50, 14, 64'(w_a[49:0]), 64'(w_b), w_s));
         if (w_valid && r50b)
            q50b.push_back(ref_add(50, 14, 64'(w_a[49:0]), 64'(w_b), w_s));
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         if (out_valid && out_ready) begin
            if (q_main.size() == 0) chk("main_spurious", out_valid, 0);
            else begin chk("main_order", out_sum, q_main.pop_front()); n_out++; end
         end
         if (v8 && w_oready) begin
            if (q8.size() == 0) chk("s8_spurious", v8, 0);
            else begin chk("s8_order", sum8, q8.pop_front()); n8++; end
         end
         if (v50a && w_oready) begin
            if (q50a.size() == 0) chk("w50_spurious", v50a, 0);
            else begin chk("w50_order", sum50a, q50a.pop_front()); n50a++; end
         end
         if (v50b && w_oready) begin
            if (q50b.size() == 0) chk("w64_spurious", v50b, 0);
            else begin chk("w64_order", sum50b, q50b.pop_front()); n50b++; end
         end
      end
   end

   // Call at posedge+1; returns at posedge+1 just after the edge that accepted the operands.
   task automatic send(input logic [47:0] a, input logic [13:0] b, input logic s);
      in_valid  = 1'b1;
      in_a      = a;
      in_b      = b;
      in_signed = s;
      @(negedge clk);
      for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
      if (!in_ready) chk("send_timeout", in_ready, 1);
      @(posedge clk); #1;
   endtask

   initial begin
      int n0;
      reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0; out_ready = 1'b1;
      w_valid = 1'b0; w_a = '0; w_b = '0; w_s = 1'b0; w_oready = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_sum", out_sum, 0);
      chk("rst_in_ready", in_ready, 1);

      // all-ones A plus unsigned one: latency 3 cycles, carry out
      @(posedge clk); #1;
      send(48'hFFFF_FFFF_FFFF, 14'h0001, 1'b0);
      in_valid = 1'b0;
      @(negedge clk); chk("t1_lat0", out_valid, 0);
      @(negedge clk); chk("t1_lat1", out_valid, 0); chk("t1_ready", in_ready, 1);
      @(negedge clk); chk("t1_valid", out_valid, 1);
      chk("t1_sum", out_sum, 49'h1_0000_0000_0000);

      // signed: -1 and most-negative B
      @(posedge clk); #1;
      send(48'h0000_0000_0005, 14'h3FFF, 1'b1);
      send(48'h0000_0000_0000, 14'h2000, 1'b1);
      in_valid = 1'b0;
      @(negedge clk); chk("t2_lat", out_valid, 0);
      @(negedge clk); chk("t2a_valid", out_valid, 1);
      chk("t2a_sum", out_sum, 49'h1_0000_0000_0004);
      @(negedge clk); chk("t2b_valid", out_valid, 1);
      chk("t2b_sum", out_sum, 49'h0_FFFF_FFFF_E000);

      // 100 back-to-back random transactions
      repeat (2) @(negedge clk);
      n0 = n_out;
      @(posedge clk); #1;
      for (int i = 0; i < 100; i++)
         send(48'({$urandom(), $urandom()}), 14'($urandom()), 1'($urandom()));
      in_valid = 1'b0;
      repeat (6) @(negedge clk);
      chk("rand_count", 64'(n_out - n0), 100);
      chk("rand_drain", 64'(q_main.size()), 0);

      // backpressure: freeze with a result at the output and a fourth operand waiting
      n0 = n_out;
      @(posedge clk); #1;
      send(48'h1234_5678_9ABC, 14'h0010, 1'b0);
      send(48'h0000_0000_0001, 14'h2000, 1'b1);
      send(48'hFFFF_FFFF_0000, 14'h1FFF, 1'b1);
      out_ready = 1'b0;
      in_a = 48'h8000_0000_0000; in_b = 14'h3FFF; in_signed = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_valid", out_valid, 1);
         chk("stall_sum", out_sum, 49'h0_1234_5678_9ACC);
         chk("stall_ready", in_ready, 0);
      end
      @(posedge clk); #1; out_ready = 1'b1;
      @(posedge clk); #1; in_valid = 1'b0;
      @(negedge clk); chk("drain_t2", out_sum, 49'h0_FFFF_FFFF_E001);
      repeat (7) @(negedge clk);
      chk("stall_count", 64'(n_out - n0), 4);
      chk("stall_drain", 64'(q_main.size()), 0);

      // reset with two transactions in flight
      @(posedge clk); #1;
      send(48'hAAAA_5555_AAAA, 14'h1234, 1'b0);
      send(48'h0F0F_0F0F_0F0F, 14'h2222, 1'b1);
      in_valid = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      chk("rst2_valid", out_valid, 0);
      chk("rst2_sum", out_sum, 0);
      chk("rst2_ready", in_ready, 1);
      repeat (6) @(negedge clk);
      chk("rst2_quiet", out_valid, 0);

      // parameter sweeps: latency per configuration, then random traffic
      @(posedge clk); #1;
      w_valid = 1'b1; w_a = 64'hFFFF_FF80; w_b = 14'h0080; w_s = 1'b1;
      @(posedge clk); #1;
      w_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("s8_lat", v8, (k == 3));
         chk("w50_lat", v50a, (k == 3));
         chk("w64_lat", v50b, (k == 0));
         if (k == 3) chk("s8_sum", sum8, 33'h1_FFFF_FF00);
         if (k == 3) chk("w50_sum", sum50a, 51'h0_0001_0000_0000);
         if (k == 0) chk("w64_sum", sum50b, 51'h0_0001_0000_0000);
      end
      @(posedge clk); #1;
      w_valid = 1'b1;
      for (int i = 0; i < 60; i++) begin
         w_a = {$urandom(), $urandom()};
         w_b = 14'($urandom());
         w_s = 1'($urandom());
         @(posedge clk); #1;
      end
      w_valid = 1'b0;
      repeat (8) @(negedge clk);
      chk("s8_count", 64'(n8), 61);
      chk("w50_count", 64'(n50a), 61);
      chk("w64_count", 64'(n50b), 61);
      chk("sweep_drain", 64'(q8.size() + q50a.size() + q50b.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
